mult_appx_stat: RTL



---
 rtl/mult_appx_stat.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mult_appx_stat.sv
// Two-stage W x W unsigned fixed-point multiplier producing exact and truncated-array
// approximate products, with saturating running statistics of their difference.
module mult_appx_stat #(
    parameter int W     = 5,
    parameter int TRUNC = 4,
    parameter int CW    = 16,
    parameter int SW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          mode,
    input  logic          stat_clr,
    output logic          out_valid,
    output logic [W-1:0]  out_y,
    output logic [W-1:0]  out_err,
    output logic [CW-1:0] sample_cnt,
    output logic [CW-1:0] err_cnt,
    output logic [SW-1:0] err_sum,
    output logic [W-1:0]  err_max
);

    localparam int PW = 2 * W;
    localparam int AW = ((SW > W) ? SW : W) + 1;
    localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] KEEP    = ~((ONE_P << TRUNC) - ONE_P);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Widen before adding so the carry out is visible, then clamp at all-ones.
    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] acc,
                                              input logic [W-1:0]  inc);
        logic [AW-1:0] sum;
        sum = {{(AW-SW){1'b0}}, acc} + {{(AW-W){1'b0}}, inc};
        if (sum > {{(AW-SW){1'b0}}, {SW{1'b1}}})
            return {SW{1'b1}};
        return sum[SW-1:0];
    endfunction

    // ---- stage 1: operand capture ----
    logic          vld_p1_q;
    logic [W-1:0]  a_p1_q;
    logic [W-1:0]  b_p1_q;
    logic          mode_p1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            a_p1_q    <= '0;
            b_p1_q    <= '0;
            mode_p1_q <= 1'b0;
        end else begin
            vld_p1_q  <= in_valid;
            a_p1_q    <= in_a;
            b_p1_q    <= in_b;
            mode_p1_q <= mode;
        end
    end

    // ---- stage 1 -> 2: exact and truncated products ----
    logic [PW-1:0] prod_ex;
    logic [PW-1:0] prod_apx;
    logic [W-1:0]  exact_w;
    logic [W-1:0]  apx_w;
    logic [W-1:0]  y_d;
    logic [W-1:0]  err_d;

    // Each row's bit k sits in column k, so masking a shifted row drops its low columns.
    always_comb begin
        prod_ex  = {{W{1'b0}}, a_p1_q} * {{W{1'b0}}, b_p1_q};
        prod_apx = '0;
        for (int i = 0; i < W; i++) begin
            if (a_p1_q[i])
                prod_apx = prod_apx + (({{W{1'b0}}, b_p1_q} << i) & KEEP);
        end
    end

    assign exact_w = prod_ex[PW-1:W];
    assign apx_w   = prod_apx[PW-1:W];
    assign err_d   = exact_w - apx_w;
    assign y_d     = mode_p1_q ? apx_w : exact_w;

    // ---- stage 2: result register ----
    logic          vld_p2_q;
    logic [W-1:0]  y_p2_q;
    logic [W-1:0]  err_p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q <= 1'b0;
            y_p2_q   <= '0;
            err_p2_q <= '0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                y_p2_q   <= y_d;
                err_p2_q <= err_d;
            end
        end
    end

    // ---- statistics, fed by the presented stage-2 sample ----
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic [CW-1:0] err_cnt_q,    err_cnt_d;
    logic [SW-1:0] err_sum_q,    err_sum_d;
    logic [W-1:0]  err_max_q,    err_max_d;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_sum_d    = err_sum_q;
        err_max_d    = err_max_q;
        if (stat_clr) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            err_sum_d    = '0;
            err_max_d    = '0;
        end else if (vld_p2_q) begin
            sample_cnt_d = sat_inc(sample_cnt_q);
            if (err_p2_q != '0)
                err_cnt_d = sat_inc(err_cnt_q);
            err_sum_d = sat_add(err_sum_q, err_p2_q);
            if (err_p2_q > err_max_q)
                err_max_d = err_p2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_sum_q    <= '0;
            err_max_q    <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_sum_q    <= err_sum_d;
            err_max_q    <= err_max_d;
        end
    end

    assign out_valid  = vld_p2_q;
    assign out_y      = y_p2_q;
    assign out_err    = err_p2_q;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign err_sum    = err_sum_q;
    assign err_max    = err_max_q;

endmodule
